// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq.
// master = issuing stage, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       func;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] hi;
    logic             cout;
    logic             ovf;
    logic             zero_detect;
    logic             div_by_zero;
    logic             illegal;

    modport master (
        output in_valid, func, d1, d2, out_ready,
        input  in_ready, out_valid, s, hi, cout,
        input  ovf, zero_detect, div_by_zero, illegal
    );

    modport slave (
        input  in_valid, func, d1, d2, out_ready,
        output in_ready, out_valid, s, hi, cout,
        output ovf, zero_detect, div_by_zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: 16 single-cycle ops plus iterative mult/div.
// Define ALU_DIV_EN to build the divider (div/divu); otherwise they decode as illegal.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             fixed;
    logic [WIDTH-1:0] acc, q, b;
    logic             neg_p;

    logic             out_valid, cout_reg, ovf_reg;
    logic             zero_reg, ill_reg;
    logic [WIDTH-1:0] s_reg, hi_reg;

    logic [WIDTH-1:0] d1, d2, res, ma, mb;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum, dif, msum;
    logic             c, v, ill, multi, sgn, eq, lt;
    logic             add_ovf, sub_ovf, accept, fix_load;

    assign d1    = bus.d1;
    assign d2    = bus.d2;
    assign shamt = d2[SHW-1:0];
    assign sum   = {1'b0, d1} + {1'b0, d2};
    assign dif   = {1'b0, d1} + {1'b0, ~d2} + (WIDTH+1)'(1);
    assign eq    = d1 == d2;
    assign lt    = $signed(d1) < $signed(d2);

    assign add_ovf = (d1[WIDTH-1] == d2[WIDTH-1]) &&
                     (sum[WIDTH-1] != d1[WIDTH-1]);
    assign sub_ovf = (d1[WIDTH-1] != d2[WIDTH-1]) &&
                     (dif[WIDTH-1] != d1[WIDTH-1]);

    assign bus.in_ready = (state == IDLE) &&
                          (!out_valid || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;
    assign fix_load = (state == FIX) && fixed &&
                      (!out_valid || bus.out_ready);

`ifdef ALU_DIV_EN
    logic           div_op, is_div, dz, neg_q, neg_r, ovf_p;
    logic           dz_reg, dge;
    logic [WIDTH:0] dsh, drem;

    assign dsh  = {acc, q[WIDTH-1]};
    assign dge  = dsh >= {1'b0, b};
    assign drem = dge ? dsh - {1'b0, b} : dsh;
    assign bus.div_by_zero = dz_reg;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign msum = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);

    assign ma = (sgn && d1[WIDTH-1]) ? -d1 : d1;
    assign mb = (sgn && d2[WIDTH-1]) ? -d2 : d2;

    always_comb begin
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        ill   = 1'b0;
        multi = 1'b0;
        sgn   = 1'b0;
`ifdef ALU_DIV_EN
        div_op = 1'b0;
`endif
        case (bus.func)
            6'b000100: res = d1 << shamt;
            6'b000110: res = d1 >> shamt;
            6'b000111: res = $signed(d1) >>> shamt;
            6'b100000: begin
                res = sum[WIDTH-1:0]; c = sum[WIDTH]; v = add_ovf;
            end
            6'b100001: begin
                res = sum[WIDTH-1:0]; c = sum[WIDTH]; v = sum[WIDTH];
            end
            6'b100010: begin
                res = dif[WIDTH-1:0]; c = dif[WIDTH]; v = sub_ovf;
            end
            // borrow is the absence of carry in d1 + ~d2 + 1
            6'b100011: begin
                res = dif[WIDTH-1:0]; c = dif[WIDTH]; v = !dif[WIDTH];
            end
            6'b100100: res = d1 & d2;
            6'b100101: res = d1 | d2;
            6'b100110: res = d1 ^ d2;
            6'b101000: res = WIDTH'(eq);
            6'b101001: res = WIDTH'(!eq);
            6'b101010: res = WIDTH'(lt);
            6'b101011: res = WIDTH'(!lt && !eq);
            6'b101100: res = WIDTH'(lt || eq);
            6'b101101: res = WIDTH'(!lt);
            6'b011000: begin multi = 1'b1; sgn = 1'b1; end
            6'b011001: multi = 1'b1;
`ifdef ALU_DIV_EN
            6'b011010: begin
                multi = 1'b1; sgn = 1'b1; div_op = 1'b1;
            end
            6'b011011: begin multi = 1'b1; div_op = 1'b1; end
`endif
            default: ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fixed     <= 1'b0;
            acc       <= '0;
            q         <= '0;
            b         <= '0;
            neg_p     <= 1'b0;
            out_valid <= 1'b0;
            s_reg     <= '0;
            hi_reg    <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            ill_reg   <= 1'b0;
`ifdef ALU_DIV_EN
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            ovf_p  <= 1'b0;
            dz_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept && multi) begin
                    state <= BUSY;
                    cnt   <= CW'(WIDTH);
                    fixed <= 1'b0;
                    acc   <= '0;
                    q     <= ma;
                    b     <= mb;
                    neg_p <= sgn && (d1[WIDTH-1] ^ d2[WIDTH-1]);
`ifdef ALU_DIV_EN
                    is_div <= div_op;
                    dz     <= div_op && (d2 == '0);
                    // a zero divisor leaves q all ones; keep it unsigned
                    neg_q  <= div_op && sgn && (d2 != '0) &&
                              (d1[WIDTH-1] ^ d2[WIDTH-1]);
                    neg_r  <= div_op && sgn && d1[WIDTH-1];
                    ovf_p  <= div_op && sgn && (&d2) &&
                              (d1 == {1'b1, {(WIDTH-1){1'b0}}});
`endif
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        acc <= drem[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], dge};
                    end else begin
                        acc <= msum[WIDTH:1];
                        q   <= {msum[0], q[WIDTH-1:1]};
                    end
`else
                    acc <= msum[WIDTH:1];
                    q   <= {msum[0], q[WIDTH-1:1]};
`endif
                end
                FIX: begin
                    if (!fixed) begin
                        fixed <= 1'b1;
`ifdef ALU_DIV_EN
                        if (is_div) begin
                            if (neg_q) q <= -q;
                            if (neg_r) acc <= -acc;
                        end else if (neg_p) begin
                            {acc, q} <= -{acc, q};
                        end
`else
                        if (neg_p) {acc, q} <= -{acc, q};
`endif
                    end else if (fix_load) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept && !multi) begin
                out_valid <= 1'b1;
                s_reg     <= res;
                hi_reg    <= '0;
                cout_reg  <= c;
                ovf_reg   <= v;
                zero_reg  <= res == '0;
                ill_reg   <= ill;
`ifdef ALU_DIV_EN
                dz_reg    <= 1'b0;
`endif
            end else if (fix_load) begin
                out_valid <= 1'b1;
                s_reg     <= q;
                hi_reg    <= acc;
                cout_reg  <= 1'b0;
                zero_reg  <= q == '0;
                ill_reg   <= 1'b0;
`ifdef ALU_DIV_EN
                ovf_reg   <= ovf_p;
                dz_reg    <= dz;
`else
                ovf_reg   <= 1'b0;
`endif
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.s           = s_reg;
    assign bus.hi          = hi_reg;
    assign bus.cout        = cout_reg;
    assign bus.ovf         = ovf_reg;
    assign bus.zero_detect = zero_reg;
    assign bus.illegal     = ill_reg;
endmodule
